// File: rtl/up_down_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : up_down_counter_pkg
// Description : Shared defaults and the count type for the up/down counter.
// Revision    : 1.0 - initial release
// ============================================================================
package up_down_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH       = 4;
    localparam int unsigned DEFAULT_RESET_VALUE = 0;

    typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage
`default_nettype wire

// File: rtl/up_down_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : up_down_counter_if
// Description : Control inputs and count output of the up/down counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface up_down_counter_if
    import up_down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             enable;
    logic             set;
    logic [WIDTH-1:0] set_value;
    logic             up_down;
    logic [WIDTH-1:0] count;

    modport master (
        output enable,
        output set,
        output set_value,
        output up_down,
        input  count
    );

    modport slave (
        input  enable,
        input  set,
        input  set_value,
        input  up_down,
        output count
    );

endinterface
`default_nettype wire

// File: rtl/up_down_counter_next.sv
`default_nettype none
// ============================================================================
// Module      : up_down_counter_next
// Description : Next-count logic: load, then count up/down, then hold.
// Revision    : 1.0 - initial release
// ============================================================================
module up_down_counter_next
    import up_down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  wire logic [WIDTH-1:0] count,
    input  wire logic             set,
    input  wire logic [WIDTH-1:0] set_value,
    input  wire logic             enable,
    input  wire logic             up_down,
    output logic      [WIDTH-1:0] next_count
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    // Addition and subtraction wrap silently at WIDTH bits.
    always_comb begin
        next_count = count;
        if (set) begin
            next_count = set_value;
        end else if (enable) begin
            if (up_down) begin
                next_count = count + c_ONE;
            end else begin
                next_count = count - c_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/up_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : up_down_counter
// Description : Loadable wrapping up/down counter with asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module up_down_counter
    import up_down_counter_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned RESET_VALUE = DEFAULT_RESET_VALUE
) (
    input  wire logic         clk,
    input  wire logic         reset,
    up_down_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] c_RESET_COUNT = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next_count;

    up_down_counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .count      (r_count),
        .set        (bus.set),
        .set_value  (bus.set_value),
        .enable     (bus.enable),
        .up_down    (bus.up_down),
        .next_count (w_next_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= c_RESET_COUNT;
        end else begin
            r_count <= w_next_count;
        end
    end

    assign bus.count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_up_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_up_down_counter
// Description : Directed and random checks of up_down_counter against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_up_down_counter;

    localparam int unsigned W   = 4;
    localparam int          MOD = 1 << W;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;
    int   model;

    up_down_counter_if #(.WIDTH(W)) bus ();

    up_down_counter #(
        .WIDTH       (W),
        .RESET_VALUE (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: reset wins, then load, then +/-1 modulo 2^W, else hold.
    task automatic step(input string tag);
        @(posedge clk);
        if (!reset)             model = 0;
        else if (bus.set)       model = int'(bus.set_value);
        else if (bus.enable)    model = bus.up_down ? (model + 1) % MOD
                                                    : (model + MOD - 1) % MOD;
        #1 check(tag, int'(bus.count), model);
    endtask

    task automatic drive(input logic s, input int sv, input logic en, input logic up);
        bus.set       = s;
        bus.set_value = W'(sv);
        bus.enable    = en;
        bus.up_down   = up;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        model   = 0;
        reset   = 1'b0;
        drive(1'b0, 0, 1'b1, 1'b1);

        #1 check("reset_initial", int'(bus.count), 0);
        for (int i = 0; i < 5; i++) step("reset_held");

        reset = 1'b1;
        drive(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) step("hold_zero");

        drive(1'b1, 9, 1'b1, 1'b1);
        step("load_priority_9");
        drive(1'b1, 0, 1'b1, 1'b1);
        step("load_0");

        drive(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step("count_up");
        drive(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step("count_down");

        drive(1'b1, 15, 1'b0, 1'b1);
        step("load_15");
        drive(1'b0, 0, 1'b1, 1'b1);
        step("wrap_up");
        drive(1'b1, 0, 1'b0, 1'b0);
        step("load_0b");
        drive(1'b0, 0, 1'b1, 1'b0);
        step("wrap_down");

        // Asynchronous reset between edges while counting from 7.
        drive(1'b1, 7, 1'b1, 1'b1);
        step("load_7");
        drive(1'b0, 0, 1'b1, 1'b1);
        #2 reset = 1'b0;
        model = 0;
        #1 check("async_reset", int'(bus.count), 0);
        for (int i = 0; i < 2; i++) step("async_reset_held");
        reset = 1'b1;
        step("after_reset_up");

        drive(1'b1, 5, 1'b0, 1'b1);
        step("load_5");
        drive(1'b0, 0, 1'b0, 1'b0);
        step("disable_a");
        drive(1'b0, 0, 1'b0, 1'b1);
        step("disable_b");

        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 7) == 0), int'($urandom_range(0, MOD - 1)),
                  ($urandom_range(0, 3) != 0), 1'($urandom));
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b0;
                model = 0;
                #1 check("rand_async", int'(bus.count), 0);
            end else begin
                reset = 1'b1;
            end
            step("random");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/up_down_counter.md
UP_DOWN_COUNTER -- requirements
Module: up_down_counter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and reset as in the codebase; polarity and synchronicity are fixed.
REQ-002 Parameter WIDTH, default 4, SHALL set the counter width in bits.
REQ-003 Parameter RESET_VALUE, default 0, SHALL set the count value forced by reset.
REQ-004 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-005 Port reset, input, 1 bit: asynchronous active-low reset; 0 forces reset.
REQ-006 Port enable, input, 1 bit: count enable.
REQ-007 Port set, input, 1 bit: synchronous load strobe.
REQ-008 Port set_value, input, WIDTH bits: value loaded when set=1.
REQ-009 Port up_down, input, 1 bit: direction; 1 = up, 0 = down.
REQ-010 Port count, output, WIDTH bits: registered counter value, driven directly from a flop.

Function
REQ-011 The block SHALL update count only on the rising edge of clk, except for reset.
REQ-012 Priority on each edge SHALL be: set, then enable, then hold.
REQ-013 If set=1, next count SHALL be set_value, regardless of enable and up_down.
REQ-014 If set=0, enable=1 and up_down=1, next count SHALL be count+1 modulo 2^WIDTH.
- Up wrap: 15 -> 0 for WIDTH=4.
REQ-015 If set=0, enable=1 and up_down=0, next count SHALL be count-1 modulo 2^WIDTH.
- Down wrap: 0 -> 15 for WIDTH=4.
REQ-016 If set=0 and enable=0, count SHALL hold its value.
REQ-017 Latency SHALL be one cycle: a change sampled at edge N is visible on count after edge N.
REQ-018 A direction change while enable=1 SHALL take effect on the first edge that samples the new up_down.
- No extra step and no skipped step.
REQ-019 The block SHALL have no handshake, no overflow flag and no saturation; wrap is silent.
REQ-020 Inputs are synchronous to clk; the block SHALL NOT add input synchronizers.

Reset
REQ-021 While reset=0, count SHALL be RESET_VALUE (0) immediately, independent of clk.
REQ-022 Reset SHALL override set and enable.
REQ-023 After reset deasserts, the first rising edge with reset=1 SHALL apply the REQ-012 rules.
REQ-024 Reset asserted mid-count SHALL clear count at once, with no partial update.

Structure
REQ-025 Package up_down_counter_pkg SHALL hold the default WIDTH, the default RESET_VALUE and a count_t typedef of WIDTH bits.
REQ-026 Combinational next-state logic SHALL be one sub-module, up_down_counter_next.
- Inputs: count, set, set_value, enable, up_down.
- Output: next count.
REQ-027 The top level SHALL contain only the count register with asynchronous reset and the instance of up_down_counter_next.

Verification
REQ-028 Reset and hold: reset=0 for 5 cycles with enable=1 -> count=0 throughout; then reset=1, enable=0 -> count holds 0.
REQ-029 Load with priority: set=1, set_value=9, enable=1, up_down=1 for one edge -> count=9, not 10; set_value=0 -> count=0.
REQ-030 Count up then down: from 0, enable=1, up_down=1 for 5 edges -> count 1,2,3,4,5; then up_down=0 for 5 edges -> 4,3,2,1,0.
REQ-031 Wrap-around: load 15 then count up one edge -> 0; load 0 then count down one edge -> 15.
REQ-032 Asynchronous reset mid-count: count=7, enable=1, drop reset between edges -> count=0 before the next edge; it stays 0 until reset=1.
REQ-033 Disable: count=5, enable=0, up_down toggling for 2 edges -> count stays 5.
